// File: rtl/conv_result_collector.sv
// rtl/conv_result_collector.sv - six-lane skew buffer, lane sum, binarize and 16-bit pack
// Optional raw sum outputs (sum_out, sum_valid) when COLLECTOR_RAW_SUM_EN is defined.
module conv_result_collector #(
  parameter int N     = 6,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din_0,
  input  logic [15:0] din_1,
  input  logic [15:0] din_2,
  input  logic [15:0] din_3,
  input  logic [15:0] din_4,
  input  logic [15:0] din_5,
  input  logic [5:0]  ivalid,
  input  logic [5:0]  idone,
  output logic        in_ready,
  output logic [15:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output logic        overflow
`ifdef COLLECTOR_RAW_SUM_EN
  ,
  output logic [18:0] sum_out,
  output logic        sum_valid
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [15:0]   din_a  [N];
  logic [15:0]   mem    [N][DEPTH];
  logic [AW-1:0] wr_ptr [N];
  logic [AW-1:0] rd_ptr [N];
  logic [CW-1:0] cnt    [N];
  logic [N-1:0]  push;
  logic [N-1:0]  full;
  logic [N-1:0]  done_flags;
  logic          all_nonempty;
  logic          all_empty;
  logic          all_low;
  logic          stall;
  logic          pop;
  logic          act;
  logic          load_full;
  logic          load_part;
  logic          clear;
  logic [18:0]   sum;
  logic [15:0]   pack;
  logic [3:0]    bit_cnt;

  assign din_a[0] = din_0;
  assign din_a[1] = din_1;
  assign din_a[2] = din_2;
  assign din_a[3] = din_3;
  assign din_a[4] = din_4;
  assign din_a[5] = din_5;

  // Lane occupancy summaries, accepted writes and the sign-extended sum of all heads
  always_comb begin
    all_nonempty = 1'b1;
    all_empty    = 1'b1;
    all_low      = 1'b1;
    sum          = '0;
    push         = '0;
    full         = '0;
    for (int k = 0; k < N; k++) begin
      full[k] = (cnt[k] == CW'(DEPTH));
      push[k] = (state == S_RUN) && ivalid[k] && !full[k];
      if (cnt[k] == '0) all_nonempty = 1'b0;
      else              all_empty    = 1'b0;
      if (cnt[k] > CW'(DEPTH - 2)) all_low = 1'b0;
      sum = sum + {{3{mem[k][rd_ptr[k]][15]}}, mem[k][rd_ptr[k]]};
    end
  end

  assign clear      = (state == S_IDLE) && start;
  assign stall      = (bit_cnt == 4'd15) && out_valid && !out_ready;
  assign pop        = (state == S_RUN) && all_nonempty && !stall;
  assign act        = ~sum[18];
  assign load_full  = pop && (bit_cnt == 4'd15);
  assign load_part  = (state == S_FLUSH) && (bit_cnt != 4'd0) && (!out_valid || out_ready);
  assign in_ready   = (state == S_RUN) && all_low;
  assign frame_done = (state == S_DONE);

  // Lane FIFO storage; data needs no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= din_a[k];
    end
  end

  // Lane FIFO pointers and counts; a pop always takes one head from every lane
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < N; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop)     rd_ptr[k] <= rd_ptr[k] + AW'(1);
        cnt[k] <= cnt[k] + CW'(push[k]) - CW'(pop);
      end
    end
  end

  // Frame sequencing, sticky per-lane done flags and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      done_flags <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            done_flags <= '0;
            overflow   <= 1'b0;
          end
        end
        S_RUN: begin
          done_flags <= done_flags | idone;
          if (|(ivalid & full)) overflow <= 1'b1;
          if ((&done_flags) && all_empty) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if ((bit_cnt == 4'd0) && !out_valid) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Activation packing and the output word register with its handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      pack      <= '0;
      bit_cnt   <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      pack    <= '0;
      bit_cnt <= '0;
    end else begin
      if (load_full) begin
        out_word <= {act, pack[14:0]};
        pack     <= '0;
        bit_cnt  <= '0;
      end else if (pop) begin
        pack[bit_cnt] <= act;
        bit_cnt       <= bit_cnt + 4'd1;
      end else if (load_part) begin
        out_word <= pack;
        pack     <= '0;
        bit_cnt  <= '0;
      end
      if (load_full || load_part)  out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

`ifdef COLLECTOR_RAW_SUM_EN
  // Registered copy of the lane sum, one pulse of sum_valid per pop
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= pop;
      if (pop) sum_out <= sum;
    end
  end
`endif

endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Receiving end of the six-lane convolution output interface. Buffers the per-lane `dout`/`ovalid`/`done` streams from the convolution engine in small skew FIFOs, pops one value from every lane together, sums the six partial results, binarizes the sum (sign bit → 1/0 activation), and packs activations into 16-bit words. Packed words leave through a valid/ready handshake toward the feature-map write buffer of the next layer.

## Interface
- `N`, 6 — number of input lanes; fixed at 6, other values unsupported.
- `DEPTH`, 4 — entries per lane skew FIFO; power of two, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse; begins a frame (IDLE→RUN).
- `din_0`..`din_5`  in  16 each  signed lane results.
- `ivalid`  in  6  per-lane valid; bit k qualifies `din_k`.
- `idone`  in  6  per-lane pulse: lane k has delivered its last value for the frame.
- `in_ready`  out  1  backpressure to the convolution engine.
- `out_word`  out  16  packed activations; bit 0 = oldest.
- `out_valid`  out  1  `out_word` holds a word.
- `out_ready`  in  1  downstream accepts.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `overflow`  out  1  sticky: a write hit a full lane FIFO.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: lane writes ignored; `start` → RUN, clearing FIFOs, pack register, bit counter, done flags, `overflow`.
- RUN: `ivalid[k]` pushes `din_k` into lane FIFO k. Write to a full FIFO is dropped; `overflow` set, held until `start` or `rst`.
- `in_ready` = 1 in RUN when every lane FIFO holds ≤ DEPTH−2 entries, else 0. One cycle of in-flight data is absorbed.
- Pop condition: all six FIFOs non-empty and the pack stage is not stalled. A pop removes one head from every lane in the same cycle.
- Sum: sign-extend each head to 19 bits and add all six (no overflow possible). Activation bit = 1 if sum ≥ 0, else 0.
- Packing: each pop shifts the activation into the pack register at position `bit_cnt`, then increments `bit_cnt` (0..15).
- The 16th bit completes the word. The word loads into `out_word` on that edge, provided the output register is empty or is being accepted in the same cycle.
- Stall: if `bit_cnt`=15 and the output register is full and not being accepted, the pop is suppressed.
- Done tracking: `idone[k]` sets sticky flag k.
- RUN→FLUSH when all six flags are set and all FIFOs are empty.
- FLUSH: if `bit_cnt`≠0, the partial word (upper bits zero) loads into the output register when it is free, and `bit_cnt` is cleared. Once no partial word remains and the output register is empty → DONE.
- DONE: `frame_done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored.
- `idone[k]` with `ivalid[k]` in the same cycle: the value is pushed and then counted as last.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_word`=0, `frame_done`=0, `overflow`=0, state IDLE, `bit_cnt`=0.
- A lane write at edge e is visible at the FIFO head after e. The earliest pop is at edge e+1.
- The word-completing pop at edge p gives `out_valid`=1 after edge p.
- Handshake: a transfer happens when `out_valid` & `out_ready` at a rising edge. `out_word` is stable while `out_valid`=1 and not accepted.
- Throughput: one pop per cycle, so one word per 16 cycles with no stalls.
- `rst` mid-frame: returns to IDLE on that edge; FIFOs are emptied and any partial word is discarded.

## Configuration
- `COLLECTOR_RAW_SUM_EN` defined: adds outputs `sum_out` (19 bits, signed) and `sum_valid` (1). These are registered and show the six-lane sum one cycle after each pop, with `sum_valid` pulsing once per pop. Reset value 0.
- Not defined: these ports and their registers do not exist. Binarized behaviour is identical in both builds.

## Test plan
- Aligned lanes: all lanes `ivalid`=1 for 16 cycles. Lanes 0–2 carry +5 and lanes 3–5 carry −3, so the sum is +6 → bit 1. Frame 1 → `out_word`=16'hFFFF. Frame 2, negative case: lanes 0–2 carry +5 and lanes 3–5 carry −6, so the sum is −3 → bit 0. Frame 2 → `out_word`=16'h0000.
- Skewed lanes: lane 5 delayed by 2 cycles relative to the others. Pops begin only after lane 5's first write, and no values are lost.
- Zero sum: all heads are 0 → activation bit 1. Alternating +1 and −1 sums over 16 pops → `out_word`=16'h5555.
- Backpressure: hold `out_ready`=0 across two completed words. Pops stall at `bit_cnt`=15, `in_ready` drops once a FIFO reaches DEPTH−1 entries, and releasing `out_ready` delivers both words in order.
- Partial flush: 20 pops, then `idone`=6'h3F. Two words are emitted: the second has bits 0–3 set and bits 4–15 zero. `frame_done` pulses once.
- Overflow and reset: write to lane 0 while it is full → `overflow`=1 and the value is dropped. Asserting `rst` mid-frame → all outputs return to 0 on the next cycle.
